attack_anim_sequencer: RTL and testbench
========================================

# attack_anim_sequencer

Parametrised attack animation sequencer for the battle screen. It replaces the fixed-timing, two-sprite attack blocks with one engine. The engine generates the animation frame tick and counts frames up to a programmable end frame. It moves the attacker along a ping-pong dash and sequences up to NUM_SPRITES sprite drawers through an enable/done handshake. It also muxes the active drawer's pixel stream onto a single VGA plot bus.

## Interface
- FRAME_DIV, 833334: clock cycles per animation frame (60 Hz at 50 MHz); must be ≥2.
- CNT_W, 6: frame counter width.
- SHIFT_FRAME, 50: frame at which `shift` pulses and channels 1..N-1 start drawing.
- END_FRAME, 60: last frame; must satisfy SHIFT_FRAME ≤ END_FRAME < 2^CNT_W.
- NUM_SPRITES, 2: drawer channels; channel 0 is the attacker; must be ≥1.
- X_W / Y_W / C_W, 9 / 8 / 3: pixel coordinate and colour widths.
- BASE_X / BASE_Y, 65 / 93: attacker anchor position.
- STEP, 1: dash pixels per frame.
- DASH_MAX, 40: maximum dash offset.

Ports:
- clock  in  1  system clock; all state is on the rising edge.
- reset_all  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to run an attack; ignored while busy.
- abort  in  1  synchronous cancel; has priority over everything except reset.
- draw_en  out  NUM_SPRITES  one-hot level enable to sprite drawer i.
- draw_done  in  NUM_SPRITES  drawer i completion pulse.
- spr_x / spr_y / spr_c  in  NUM_SPRITES*X_W / *Y_W / *C_W  packed drawer pixel outputs; channel i occupies slice i.
- spr_plot  in  NUM_SPRITES  drawer write strobes.
- atk_x  out  X_W  attacker x position = BASE_X + dash offset, truncated to X_W.
- atk_y  out  Y_W  constant BASE_Y.
- out_x / out_y / out_colour / out_plot  out  X_W / Y_W / C_W / 1  muxed pixel bus.
- frame_pulse  out  1  one-cycle animation tick.
- frame_count  out  CNT_W  current frame number.
- shift  out  1  one-cycle pulse when frame_count becomes SHIFT_FRAME.
- done  out  1  one-cycle pulse when frame_count becomes END_FRAME.
- busy  out  1  high from start acceptance until done or abort.

## Operation
FSM states: IDLE, DRAW, WAIT_FRAME.

- **IDLE**
  - A high `start` clears frame_count, the dash offset, the direction (set to right), the divider and the pending flag.
  - It then sets channel index ch=0 and enters DRAW.
- **DRAW**
  - Holds draw_en[ch]=1.
  - When draw_done[ch] is sampled high, draw_en drops on the next cycle and the next channel is chosen:
    - If frame_count ≥ SHIFT_FRAME and ch < NUM_SPRITES-1: ch+1, stay in DRAW.
    - Otherwise: go to WAIT_FRAME.
  - draw_done on a non-selected channel is ignored.
- **WAIT_FRAME**
  - Leaves when a frame tick is pending.
  - On leaving, it consumes the tick, increments frame_count and updates the dash.
  - If the new frame_count equals END_FRAME: pulse `done`, drop `busy`, go to IDLE.
  - Otherwise: set ch=0 and go to DRAW.
- **Frame divider**
  - Runs only while busy and counts 0..FRAME_DIV-1.
  - frame_pulse fires on the terminal count.
  - A tick arriving while in DRAW sets the pending flag, so no tick is lost.
  - Further ticks while a tick is already pending are dropped: at most one frame is credited per wait.
- **Dash update** (once per consumed frame):
  - Direction right:
    - If offset+STEP ≤ DASH_MAX: offset += STEP.
    - Otherwise: direction becomes left and offset = offset-STEP, saturating at 0.
  - Direction left: offset = offset-STEP, saturating at 0. The offset stays at 0 once reached.
  - Offset arithmetic is X_W+1 bits wide, so there is no overflow in the comparison.
- **shift** pulses in the same cycle that frame_count is written to SHIFT_FRAME.
- **Aborts and restarts**
  - abort while busy → IDLE next cycle: draw_en=0, busy=0, no done, no shift. frame_count holds its value.
  - start and abort in the same cycle in IDLE: abort wins and start is ignored.
- **Pixel mux**
  - In DRAW: out_* = slice ch of spr_*.
  - Otherwise: out_x/out_y/out_colour = 0 and out_plot = 0.
  - The mux is combinational from the registered ch and state.
- **Reset values**: every output is 0 except atk_x=BASE_X and atk_y=BASE_Y. The FSM is in IDLE.

## Timing
- start sampled at edge t → busy=1 and draw_en[0]=1 from t+1.
- draw_done[ch] high at edge k → draw_en[ch]=0 at k+1.
  - The next channel's draw_en is asserted at k+1 (a zero-gap switch) or WAIT_FRAME is entered at k+1.
- Pending tick at WAIT_FRAME entry → leave one cycle later.
  - frame_count, atk_x, shift and done all update on that edge.
- The first frame_pulse comes FRAME_DIV cycles after start acceptance.
- done and busy falling occur on the same edge.

## Test plan
Parameters for all scenarios: FRAME_DIV=4, SHIFT_FRAME=3, END_FRAME=5, NUM_SPRITES=2, STEP=2, DASH_MAX=4, BASE_X=65. Drawers answer done 1 cycle after enable.

1. **Reset mid-run**: reset_all low → busy=0, draw_en=00, frame_count=0, atk_x=65, out_plot=0, all asynchronously.
2. **Full run**: start → atk_x sequence 65, 67, 69, 67, 65, 65 over frames 0..5.
   - shift pulses exactly once at frame 3.
   - done pulses once at frame 5, with busy low on the same cycle.
   - draw_en[1] is never asserted before frame 3, and is asserted once per frame in frames 3–4.
3. **Slow drawer**: drawer 0 takes 10 cycles → exactly one frame credited per wait, frame_count increments by 1 per loop, no hang.
4. **Abort during DRAW of channel 1 at frame 4** → next cycle draw_en=00, busy=0; no done; frame_count stays at 4. A subsequent start restarts from frame 0.
5. **start while busy** → ignored: frame_count is not reset and run length is unchanged.
6. **Pixel mux**: drive spr_x={9'd180, 9'd70} and spr_plot=2'b11.
   - out_x=70 during a channel 0 draw and out_x=180 during a channel 1 draw.
   - out_plot=0 in WAIT_FRAME.

Source files
------------

// File: rtl/attack_anim_sequencer.sv
// -----------------------------------------------------------------------------
// attack_anim_sequencer
//
// Battle-screen attack animation engine.
// - Divides the system clock down to an animation frame tick.
// - Counts frames from 0 up to END_FRAME.
// - Moves the attacker along a ping-pong dash.
// - Sequences up to NUM_SPRITES sprite drawers through an enable/done
//   handshake, and muxes the active drawer's pixel stream onto one plot bus.
//
// Ports
//   clock        in   system clock, all state on the rising edge
//   reset_all    in   asynchronous active-low reset
//   start        in   one-cycle run request, ignored while busy
//   abort        in   synchronous cancel, highest priority after reset
//   draw_en      out  one-hot level enable per drawer
//   draw_done    in   per-drawer completion pulse
//   spr_x/y/c    in   packed drawer pixel buses, channel i in slice i
//   spr_plot     in   per-drawer write strobe
//   atk_x/atk_y  out  attacker position (BASE_X + dash offset, BASE_Y)
//   out_x/out_y/out_colour/out_plot  out  muxed pixel bus
//   frame_pulse  out  one-cycle animation tick
//   frame_count  out  current frame number
//   shift        out  pulse when frame_count becomes SHIFT_FRAME
//   done         out  pulse when frame_count becomes END_FRAME
//   busy         out  high from start acceptance until done or abort
// -----------------------------------------------------------------------------
module attack_anim_sequencer #(
  parameter int FRAME_DIV   = 833334,
  parameter int CNT_W       = 6,
  parameter int SHIFT_FRAME = 50,
  parameter int END_FRAME   = 60,
  parameter int NUM_SPRITES = 2,
  parameter int X_W         = 9,
  parameter int Y_W         = 8,
  parameter int C_W         = 3,
  parameter int BASE_X      = 65,
  parameter int BASE_Y      = 93,
  parameter int STEP        = 1,
  parameter int DASH_MAX    = 40
) (
  input  logic                       clock,
  input  logic                       reset_all,
  input  logic                       start,
  input  logic                       abort,
  output logic [NUM_SPRITES-1:0]     draw_en,
  input  logic [NUM_SPRITES-1:0]     draw_done,
  input  logic [NUM_SPRITES*X_W-1:0] spr_x,
  input  logic [NUM_SPRITES*Y_W-1:0] spr_y,
  input  logic [NUM_SPRITES*C_W-1:0] spr_c,
  input  logic [NUM_SPRITES-1:0]     spr_plot,
  output logic [X_W-1:0]             atk_x,
  output logic [Y_W-1:0]             atk_y,
  output logic [X_W-1:0]             out_x,
  output logic [Y_W-1:0]             out_y,
  output logic [C_W-1:0]             out_colour,
  output logic                       out_plot,
  output logic                       frame_pulse,
  output logic [CNT_W-1:0]           frame_count,
  output logic                       shift,
  output logic                       done,
  output logic                       busy
);

  localparam int CH_W  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int DIV_W = $clog2(FRAME_DIV);

  typedef enum logic [1:0] {IDLE, DRAW, WAIT_FRAME} state_t;

  state_t                 state_q;
  logic [CH_W-1:0]        ch_q;
  logic [CNT_W-1:0]       frame_count_q;
  logic [X_W:0]           offset_q;
  logic                   dir_left_q;
  logic [DIV_W-1:0]       div_q;
  logic                   pending_q;
  logic                   busy_q;
  logic [NUM_SPRITES-1:0] draw_en_q;
  logic                   shift_q;
  logic                   done_q;
  logic                   frame_pulse_q;

  logic [CNT_W-1:0]       frame_count_d;
  logic [X_W:0]           offset_d;
  logic                   dir_left_d;
  logic [X_W:0]           offset_up;
  logic [X_W:0]           offset_dn;
  logic [CH_W-1:0]        ch_d;
  logic                   tick;

  function automatic logic [NUM_SPRITES-1:0] onehot(input logic [CH_W-1:0] idx);
    logic [NUM_SPRITES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign tick          = busy_q && (div_q == DIV_W'(FRAME_DIV - 1));
  assign frame_count_d = frame_count_q + CNT_W'(1);
  assign ch_d          = ch_q + CH_W'(1);

  // Ping-pong dash: climb until the next step would pass DASH_MAX, then
  // turn around and descend, parking at zero for the rest of the run.
  always_comb begin
    offset_up  = offset_q + (X_W+1)'(STEP);
    offset_dn  = (offset_q >= (X_W+1)'(STEP)) ? (offset_q - (X_W+1)'(STEP)) : '0;
    offset_d   = offset_dn;
    dir_left_d = 1'b1;
    if (!dir_left_q && (offset_up <= (X_W+1)'(DASH_MAX))) begin
      offset_d   = offset_up;
      dir_left_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_all) begin
    if (!reset_all) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      frame_count_q <= '0;
      offset_q      <= '0;
      dir_left_q    <= 1'b0;
      div_q         <= '0;
      pending_q     <= 1'b0;
      busy_q        <= 1'b0;
      draw_en_q     <= '0;
      shift_q       <= 1'b0;
      done_q        <= 1'b0;
      frame_pulse_q <= 1'b0;
    end else begin
      shift_q       <= 1'b0;
      done_q        <= 1'b0;
      frame_pulse_q <= 1'b0;

      // Frame divider. A tick latches into pending so a long draw never
      // loses it; repeated ticks just keep the single pending credit.
      if (busy_q) begin
        if (tick) begin
          div_q         <= '0;
          frame_pulse_q <= 1'b1;
          pending_q     <= 1'b1;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end

      if (abort) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        draw_en_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              frame_count_q <= '0;
              offset_q      <= '0;
              dir_left_q    <= 1'b0;
              div_q         <= '0;
              pending_q     <= 1'b0;
              ch_q          <= '0;
              draw_en_q     <= onehot('0);
              busy_q        <= 1'b1;
              state_q       <= DRAW;
            end
          end
          DRAW: begin
            if (draw_done[ch_q]) begin
              if ((frame_count_q >= CNT_W'(SHIFT_FRAME)) &&
                  (ch_q < CH_W'(NUM_SPRITES - 1))) begin
                ch_q      <= ch_d;
                draw_en_q <= onehot(ch_d);
              end else begin
                draw_en_q <= '0;
                state_q   <= WAIT_FRAME;
              end
            end
          end
          WAIT_FRAME: begin
            if (pending_q) begin
              // Consume the credit; a tick landing on this very edge
              // belongs to the next frame and stays pending.
              pending_q     <= tick;
              frame_count_q <= frame_count_d;
              offset_q      <= offset_d;
              dir_left_q    <= dir_left_d;
              if (frame_count_d == CNT_W'(SHIFT_FRAME)) begin
                shift_q <= 1'b1;
              end
              if (frame_count_d == CNT_W'(END_FRAME)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= IDLE;
              end else begin
                ch_q      <= '0;
                draw_en_q <= onehot('0);
                state_q   <= DRAW;
              end
            end
          end
          default: begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            draw_en_q <= '0;
          end
        endcase
      end
    end
  end

  // Unpack the per-channel pixel slices so the mux reads as an array index.
  logic [X_W-1:0] px_x [NUM_SPRITES];
  logic [Y_W-1:0] px_y [NUM_SPRITES];
  logic [C_W-1:0] px_c [NUM_SPRITES];

  for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slice
    assign px_x[gi] = spr_x[gi*X_W +: X_W];
    assign px_y[gi] = spr_y[gi*Y_W +: Y_W];
    assign px_c[gi] = spr_c[gi*C_W +: C_W];
  end

  always_comb begin
    out_x      = '0;
    out_y      = '0;
    out_colour = '0;
    out_plot   = 1'b0;
    if (state_q == DRAW) begin
      out_x      = px_x[ch_q];
      out_y      = px_y[ch_q];
      out_colour = px_c[ch_q];
      out_plot   = spr_plot[ch_q];
    end
  end

  assign atk_x       = X_W'(BASE_X) + offset_q[X_W-1:0];
  assign atk_y       = Y_W'(BASE_Y);
  assign draw_en     = draw_en_q;
  assign frame_pulse = frame_pulse_q;
  assign frame_count = frame_count_q;
  assign shift       = shift_q;
  assign done        = done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_attack_anim_sequencer.sv
module tb_attack_anim_sequencer;

  localparam int N  = 2;
  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic          clock = 1'b0;
  logic          reset_all = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  draw_en;
  logic [N-1:0]  draw_done = '0;
  logic [N*XW-1:0] spr_x = {9'd180, 9'd70};
  logic [N*YW-1:0] spr_y = {8'd20, 8'd10};
  logic [N*CW-1:0] spr_c = {3'd5, 3'd2};
  logic [N-1:0]  spr_plot = 2'b11;
  logic [XW-1:0] atk_x;
  logic [YW-1:0] atk_y;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  logic [CW-1:0] out_colour;
  logic          out_plot;
  logic          frame_pulse;
  logic [5:0]    frame_count;
  logic          shift;
  logic          done;
  logic          busy;

  attack_anim_sequencer #(
    .FRAME_DIV(4), .CNT_W(6), .SHIFT_FRAME(3), .END_FRAME(5), .NUM_SPRITES(N),
    .X_W(XW), .Y_W(YW), .C_W(CW), .BASE_X(65), .BASE_Y(93), .STEP(2), .DASH_MAX(4)
  ) dut (
    .clock(clock), .reset_all(reset_all), .start(start), .abort(abort),
    .draw_en(draw_en), .draw_done(draw_done),
    .spr_x(spr_x), .spr_y(spr_y), .spr_c(spr_c), .spr_plot(spr_plot),
    .atk_x(atk_x), .atk_y(atk_y),
    .out_x(out_x), .out_y(out_y), .out_colour(out_colour), .out_plot(out_plot),
    .frame_pulse(frame_pulse), .frame_count(frame_count),
    .shift(shift), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int fc;
    int ax;
    int sh;
    int dn;
    int bz;
  } rec_t;

  rec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   lat [N] = '{1, 1};
  bit   mon_en = 1'b0;
  int   shift_cnt = 0;
  int   done_cnt = 0;
  int   en1_rise = 0;
  int   en1_early = 0;
  bit   seen0 = 1'b0;
  bit   seen1 = 1'b0;
  bit   seenw = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Hand-computed attacker x per frame: offsets 0,2,4,2,0,0 on BASE_X=65.
  function automatic int atk_of(input int f);
    int tbl [6];
    tbl = '{65, 67, 69, 67, 65, 65};
    return tbl[f];
  endfunction

  task automatic push_rec(input int fc, input int ax, input int sh, input int dn, input int bz);
    rec_t r;
    r.fc = fc; r.ax = ax; r.sh = sh; r.dn = dn; r.bz = bz;
    exp_q.push_back(r);
  endtask

  // Start acceptance plus frames 1..last of a normal run.
  task automatic push_run(input int last);
    push_rec(0, 65, 0, 0, 1);
    for (int f = 1; f <= last; f++)
      push_rec(f, atk_of(f), (f == 3) ? 1 : 0, (f == 5) ? 1 : 0, (f == 5) ? 0 : 1);
  endtask

  // Drawer models: done pulses lat[i] cycles after the enable is seen.
  initial begin
    int cnt [N];
    foreach (cnt[i]) cnt[i] = 0;
    forever begin
      @(posedge clock); #1;
      for (int i = 0; i < N; i++) begin
        if (!draw_en[i] || draw_done[i]) begin
          draw_done[i] = 1'b0;
          cnt[i] = 0;
        end else begin
          cnt[i]++;
          if (cnt[i] >= lat[i]) draw_done[i] = 1'b1;
        end
      end
    end
  end

  // Monitor: a transaction is any change of frame_count or busy.
  initial begin
    logic [5:0] pfc;
    logic       pbz;
    logic       pen1;
    rec_t       r;
    pfc = '0; pbz = 1'b0; pen1 = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (mon_en) begin
        if (shift) shift_cnt++;
        if (done) done_cnt++;
        if (draw_en[1] && !pen1) begin
          en1_rise++;
          if (frame_count < 6'd3) en1_early++;
        end
        if (frame_count !== pfc || busy !== pbz) begin
          $display("txn fc=%0d atk_x=%0d shift=%0b done=%0b busy=%0b",
                   frame_count, atk_x, shift, done, busy);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got fc=%0d busy=%0b expected no event",
                     frame_count, busy);
          end else begin
            r = exp_q.pop_front();
            chk("frame_count", 32'(frame_count), r.fc);
            chk("atk_x", 32'(atk_x), r.ax);
            chk("shift", 32'(shift), r.sh);
            chk("done", 32'(done), r.dn);
            chk("busy", 32'(busy), r.bz);
          end
        end
      end
      pfc = frame_count; pbz = busy; pen1 = draw_en[1];
    end
  end

  // Runs one attack; optionally pulses start again at cycle inject_at.
  task automatic run(input int inject_at, output int cyc, output int fp_at);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    fp_at = -1;
    while (busy && cyc < 3000) begin
      @(posedge clock); #1;
      cyc++;
      start = (cyc == inject_at);
      if (frame_pulse && fp_at < 0) fp_at = cyc;
      if (draw_en == 2'b01 && !seen0) begin
        seen0 = 1'b1;
        chk("mux_ch0_x", 32'(out_x), 70);
        chk("mux_ch0_colour", 32'(out_colour), 2);
        chk("mux_ch0_plot", 32'(out_plot), 1);
      end
      if (draw_en == 2'b10 && !seen1) begin
        seen1 = 1'b1;
        chk("mux_ch1_x", 32'(out_x), 180);
        chk("mux_ch1_y", 32'(out_y), 20);
      end
      if (busy && draw_en == 2'b00 && !seenw) begin
        seenw = 1'b1;
        chk("mux_wait_plot", 32'(out_plot), 0);
        chk("mux_wait_x", 32'(out_x), 0);
      end
    end
    start = 1'b0;
    chk("run_terminated", 32'(busy), 0);
  endtask

  initial begin
    int cyc, fp, sh0, dn0, er0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_draw_en", 32'(draw_en), 0);
    chk("rst_frame_count", 32'(frame_count), 0);
    chk("rst_atk_x", 32'(atk_x), 65);
    chk("rst_atk_y", 32'(atk_y), 93);
    chk("rst_out_plot", 32'(out_plot), 0);
    chk("rst_frame_pulse", 32'(frame_pulse), 0);
    @(posedge clock); #3;
    reset_all = 1'b1;
    @(posedge clock); #1;
    mon_en = 1'b1;

    // Full run
    sh0 = shift_cnt; dn0 = done_cnt; er0 = en1_rise;
    push_run(5);
    run(-1, cyc, fp);
    chk("full_cycles", 32'(cyc), 21);
    chk("first_frame_pulse", 32'(fp), 4);
    chk("shift_once", 32'(shift_cnt - sh0), 1);
    chk("done_once", 32'(done_cnt - dn0), 1);
    chk("en1_early", 32'(en1_early), 0);
    chk("en1_per_frame", 32'(en1_rise - er0), 2);
    chk("full_queue_empty", 32'(exp_q.size()), 0);
    chk("mux_seen_all", 32'({seen0, seen1, seenw}), 7);

    // Slow drawer on channel 0
    lat[0] = 10;
    push_run(5);
    run(-1, cyc, fp);
    chk("slow_cycles", 32'(cyc), 57);
    chk("slow_queue_empty", 32'(exp_q.size()), 0);
    lat[0] = 1;

    // Abort during the channel-1 draw of frame 4
    repeat (3) begin @(posedge clock); #1; end
    dn0 = done_cnt;
    push_run(4);
    push_rec(4, 65, 0, 0, 0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !(frame_count == 6'd4 && draw_en[1]); i++) begin
      @(posedge clock); #1;
    end
    chk("abort_reached_frame4_ch1", 32'(frame_count == 6'd4 && draw_en[1]), 1);
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    chk("abort_draw_en", 32'(draw_en), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (6) begin @(posedge clock); #1; end
    chk("abort_hold_frame", 32'(frame_count), 4);
    chk("abort_no_done", 32'(done_cnt - dn0), 0);
    chk("abort_queue_empty", 32'(exp_q.size()), 0);

    // start together with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle_busy", 32'(busy), 0);

    // Restart from frame 0, with a start pulse mid-run that must be ignored
    push_run(5);
    run(8, cyc, fp);
    chk("restart_cycles", 32'(cyc), 21);
    chk("restart_queue_empty", 32'(exp_q.size()), 0);

    // Reset mid-run, asserted between clock edges
    repeat (2) begin @(posedge clock); #1; end
    push_run(2);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && frame_count != 6'd2; i++) begin
      @(posedge clock); #1;
    end
    chk("midrun_reached_frame2", 32'(frame_count), 2);
    chk("midrun_queue_empty", 32'(exp_q.size()), 0);
    mon_en = 1'b0;
    #3;
    reset_all = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_draw_en", 32'(draw_en), 0);
    chk("arst_frame_count", 32'(frame_count), 0);
    chk("arst_atk_x", 32'(atk_x), 65);
    chk("arst_out_plot", 32'(out_plot), 0);
    @(posedge clock); #3;
    reset_all = 1'b1;
    repeat (2) begin @(posedge clock); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
